// File: rtl/sram_like_mem_responder.sv
// SRAM-like data-port responder: word memory, fixed latency, in-order request queue, byte-masked writes.
// Define MEM_RESP_RANDOM_STALL_EN to add LFSR-driven extra head latency and accept gating.
module sram_like_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);
    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned AW = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(QUEUE_DEPTH - 1);

    logic [31:0]   mem     [2**ADDR_WIDTH];
    logic          q_wr    [QUEUE_DEPTH];
    logic [1:0]    q_size  [QUEUE_DEPTH];
    logic [AW-1:0] q_addr  [QUEUE_DEPTH];
    logic [31:0]   q_wdata [QUEUE_DEPTH];

    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      cnt;
    logic [4:0]      target;
    logic [31:0]     rdata_q;
    logic            head_valid;
    logic            push;
    logic            pop;
    logic            accept_ok;
    logic            h_wr;
    logic [1:0]      h_size;
    logic [AW-1:0]   h_addr;
    logic [31:0]     h_wdata;
    logic [31:0]     h_word;
    logic [3:0]      mask;
    logic [31-AW:0]  unused_addr_hi;

    // Upper address bits alias onto the same words.
    assign unused_addr_hi = data_addr[31:AW];

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [7:0] lfsr;
    logic [1:0] extra;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr  <= 8'hA5;
            extra <= 2'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (pop || count == '0) extra <= lfsr[1:0];
        end
    end

    assign accept_ok = ~lfsr[7];
    assign target    = 5'(LATENCY - 1) + {3'b000, extra};
`else
    assign accept_ok = 1'b1;
    assign target    = 5'(LATENCY - 1);
`endif

    assign head_valid   = (count != '0);
    assign h_wr         = q_wr[head_ptr];
    assign h_size       = q_size[head_ptr];
    assign h_addr       = q_addr[head_ptr];
    assign h_wdata      = q_wdata[head_ptr];
    assign h_word       = mem[h_addr[AW-1:2]];
    assign data_addr_ok = data_req & (count < FULL_COUNT) & accept_ok & ~rst;
    assign data_data_ok = head_valid & (cnt == target);
    assign push         = data_addr_ok;
    assign pop          = data_data_ok;
    assign data_rdata   = (data_data_ok & ~h_wr) ? h_word : rdata_q;

    always_comb begin
        mask = 4'b1111;
        case (h_size)
            2'b00:   mask = 4'b0001 << h_addr[1:0];
            2'b01:   mask = 4'b0011 << h_addr[1:0];
            default: mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            cnt      <= '0;
            rdata_q  <= '0;
        end else begin
            if (push) tail_ptr <= (tail_ptr == LAST_PTR) ? '0 : tail_ptr + PW'(1);
            if (pop)  head_ptr <= (head_ptr == LAST_PTR) ? '0 : head_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // Counter restarts whenever a new entry can become head on this edge.
            if (pop || count == '0) cnt <= '0;
            else                    cnt <= cnt + 5'd1;
            if (pop && !h_wr) rdata_q <= h_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[tail_ptr]    <= data_wr;
            q_size[tail_ptr]  <= data_size;
            q_addr[tail_ptr]  <= data_addr[AW-1:0];
            q_wdata[tail_ptr] <= data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (pop && h_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem[h_addr[AW-1:2]][8*i +: 8] <= h_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Directed bench for sram_like_mem_responder (LATENCY=3, QUEUE_DEPTH=2); random stall run when
// MEM_RESP_RANDOM_STALL_EN is defined.
module tb_sram_like_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic        req_wr    [4];
    logic [1:0]  req_size  [4];
    logic [31:0] req_addr  [4];
    logic [31:0] req_wdata [4];
    int          acc_cyc   [4];
    int          done_cyc  [4];
    logic [31:0] done_rdata[4];
    int          done_n;

    sram_like_mem_responder #(
        .ADDR_WIDTH (10),
        .LATENCY    (3),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue n queued requests from req_* holding req until accepted; log accept/completion cycles.
    task automatic run_seq(input int n, input int max_cycles);
        int  issued = 0;
        logic acc;
        done_n = 0;
        for (int k = 0; k < max_cycles && done_n < n; k++) begin
            if (issued < n) begin
                data_req   = 1'b1;
                data_wr    = req_wr[issued];
                data_size  = req_size[issued];
                data_addr  = req_addr[issued];
                data_wdata = req_wdata[issued];
            end else begin
                data_req = 1'b0;
            end
            @(negedge clk);
            acc = data_addr_ok;
            if (acc) acc_cyc[issued] = cyc;
            if (data_data_ok) begin
                done_cyc[done_n]   = cyc;
                done_rdata[done_n] = data_rdata;
                done_n++;
            end
            @(posedge clk);
            #1;
            if (acc) issued++;
        end
        data_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10;
        data_addr = 32'h0; data_wdata = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (data_addr_ok !== 1'b0) begin
            n_fail++; $display("FAIL reset_addr_ok: got %b want 0", data_addr_ok);
        end
        n_cmp++;
        if (data_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL reset_data_ok: got %b want 0", data_data_ok);
        end
        n_cmp++;
        if (data_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 00000000", data_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0; data_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        req_wr[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = 32'h40; req_wdata[0] = 32'h12345678;
        run_seq(1, 20);
        n_cmp++;
        if (done_n !== 1 || done_cyc[0] - acc_cyc[0] !== 3) begin
            n_fail++; $display("FAIL wr_latency: done %0d lat %0d want 1 lat 3",
                               done_n, done_cyc[0] - acc_cyc[0]);
        end
        req_wr[0] = 1'b0; req_wdata[0] = 32'h0;
        run_seq(1, 20);
        n_cmp++;
        if (done_n !== 1 || done_cyc[0] - acc_cyc[0] !== 3) begin
            n_fail++; $display("FAIL rd_latency: done %0d lat %0d want 1 lat 3",
                               done_n, done_cyc[0] - acc_cyc[0]);
        end
        n_cmp++;
        if (done_rdata[0] !== 32'h12345678) begin
            n_fail++; $display("FAIL rd_data: got %h want 12345678", done_rdata[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (data_data_ok !== 1'b0 || data_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL rd_hold: ok %b rdata %h want 0 12345678",
                               data_data_ok, data_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_half();
        req_wr[0] = 1'b1; req_size[0] = 2'b00; req_addr[0] = 32'h41; req_wdata[0] = 32'h0000AB00;
        req_wr[1] = 1'b1; req_size[1] = 2'b01; req_addr[1] = 32'h42; req_wdata[1] = 32'hCDEF0000;
        req_wr[2] = 1'b0; req_size[2] = 2'b10; req_addr[2] = 32'h40; req_wdata[2] = 32'h0;
        run_seq(3, 40);
        n_cmp++;
        if (done_n !== 3 || done_rdata[2] !== 32'hCDEFAB78) begin
            n_fail++; $display("FAIL byte_half: done %0d rdata %h want 3 CDEFAB78",
                               done_n, done_rdata[2]);
        end
        n_cmp++;
        if (done_rdata[0] !== 32'h12345678 || done_rdata[1] !== 32'h12345678) begin
            n_fail++; $display("FAIL wr_keeps_rdata: got %h %h want 12345678",
                               done_rdata[0], done_rdata[1]);
        end
        req_wr[0] = 1'b1; req_size[0] = 2'b01; req_addr[0] = 32'h43; req_wdata[0] = 32'h99887766;
        req_wr[1] = 1'b0; req_size[1] = 2'b11; req_addr[1] = 32'h40; req_wdata[1] = 32'h0;
        run_seq(2, 30);
        n_cmp++;
        if (done_n !== 2 || done_rdata[1] !== 32'h99EFAB78) begin
            n_fail++; $display("FAIL misaligned_half: done %0d rdata %h want 2 99EFAB78",
                               done_n, done_rdata[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            req_wr[i] = 1'b1; req_size[i] = 2'b10;
            req_addr[i] = 32'h100 + 32'(4 * i); req_wdata[i] = 32'hA0000001 + 32'(i);
        end
        run_seq(3, 40);
        for (int i = 0; i < 3; i++) req_wr[i] = 1'b0;
        run_seq(3, 40);
        n_cmp++;
        if (done_n !== 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 3", done_n);
        end
        n_cmp++;
        if (acc_cyc[1] - acc_cyc[0] !== 1 || done_cyc[0] - acc_cyc[0] !== 3) begin
            n_fail++; $display("FAIL b2b_first: acc gap %0d lat %0d want 1 3",
                               acc_cyc[1] - acc_cyc[0], done_cyc[0] - acc_cyc[0]);
        end
        n_cmp++;
        if (acc_cyc[2] - done_cyc[0] !== 1) begin
            n_fail++; $display("FAIL b2b_full_stall: third accept %0d after data_ok want 1",
                               acc_cyc[2] - done_cyc[0]);
        end
        n_cmp++;
        if (done_cyc[1] - done_cyc[0] !== 3 || done_cyc[2] - done_cyc[1] !== 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d %0d want 3 3",
                               done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (done_rdata[i] !== 32'hA0000001 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, done_rdata[i],
                                   32'hA0000001 + 32'(i));
            end
        end
    endtask

    task automatic test_raw();
        req_wr[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = 32'h200; req_wdata[0] = 32'h1;
        req_wr[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 32'h200; req_wdata[1] = 32'h0;
        run_seq(2, 30);
        n_cmp++;
        if (done_n !== 2 || done_rdata[1] !== 32'h1) begin
            n_fail++; $display("FAIL raw: done %0d rdata %h want 2 00000001", done_n, done_rdata[1]);
        end
        n_cmp++;
        if (done_cyc[1] - done_cyc[0] !== 3) begin
            n_fail++; $display("FAIL raw_spacing: got %0d want 3", done_cyc[1] - done_cyc[0]);
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int pulses = 0;
        data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h40; data_wdata = 32'h0; data_req = 1'b1;
        for (int k = 0; k < 10 && acc < 2; k++) begin
            @(negedge clk);
            if (data_addr_ok) acc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (acc !== 2) begin
            n_fail++; $display("FAIL rstmid_accepts: got %0d want 2", acc);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (data_addr_ok !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_addr_ok: got %b want 0", data_addr_ok);
        end
        for (int k = 0; k < 3; k++) begin
            if (data_data_ok) pulses++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0; data_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (data_data_ok) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL rstmid_dropped: data_ok pulses %0d want 0", pulses);
        end
        @(posedge clk); #1;
        req_wr[0] = 1'b0; req_size[0] = 2'b10; req_addr[0] = 32'h200; req_wdata[0] = 32'h0;
        run_seq(1, 20);
        n_cmp++;
        if (done_n !== 1 || done_cyc[0] - acc_cyc[0] !== 3 || done_rdata[0] !== 32'h1) begin
            n_fail++; $display("FAIL rstmid_after: done %0d lat %0d rdata %h want 1 3 00000001",
                               done_n, done_cyc[0] - acc_cyc[0], done_rdata[0]);
        end
    endtask

`ifdef MEM_RESP_RANDOM_STALL_EN
    task automatic test_random_stall();
        logic [31:0] model [64];
        logic [31:0] w;
        int          off;
        int          lat;
        for (int i = 0; i < 1064; i++) begin
            req_wr[0]    = (i < 64) ? 1'b1 : 1'($urandom_range(0, 1));
            req_size[0]  = (i < 64) ? 2'b10 : 2'($urandom_range(0, 3));
            off          = (i < 64) ? 0 : $urandom_range(0, 3);
            req_addr[0]  = {24'h0, 6'((i < 64) ? i : $urandom_range(0, 63)), 2'(off)};
            req_wdata[0] = $urandom;
            run_seq(1, 40);
            lat = done_cyc[0] - acc_cyc[0];
            n_cmp++;
            if (done_n !== 1 || lat < 3 || lat > 6) begin
                n_fail++; $display("FAIL rnd_latency%0d: done %0d lat %0d want 1 in 3..6",
                                   i, done_n, lat);
            end
            w = model[req_addr[0][7:2]];
            if (req_wr[0]) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_size[0][1] || b == off || (req_size[0] == 2'b01 && b == off + 1))
                        w[8*b +: 8] = req_wdata[0][8*b +: 8];
                end
                model[req_addr[0][7:2]] = w;
            end else begin
                n_cmp++;
                if (done_rdata[0] !== w) begin
                    n_fail++; $display("FAIL rnd_data%0d: got %h want %h", i, done_rdata[0], w);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MEM_RESP_RANDOM_STALL_EN
        test_random_stall();
`else
        test_write_read();
        test_byte_half();
        test_back_to_back();
        test_raw();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
